// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, FSM states and default latencies.
// Used by the mdu datapath and by the control decoder.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic int unsigned maxCycles(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit divider: signed (truncating) or unsigned, plus zero-divisor flag.
// Only instantiated when MDU_DIV_EN is defined.
module mdu_div (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        divZero_o
);

  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] safeB;
  logic [31:0] magQ;
  logic [31:0] magR;

  assign negA      = signed_i & dividend_i[31];
  assign negB      = signed_i & divisor_i[31];
  assign magA      = negA ? (32'd0 - dividend_i) : dividend_i;
  assign magB      = negB ? (32'd0 - divisor_i) : divisor_i;
  assign divZero_o = (divisor_i == 32'd0);

  // A zero divisor is replaced by one so the divide never produces X; the result is discarded.
  assign safeB = divZero_o ? 32'd1 : magB;
  assign magQ  = magA / safeB;
  assign magR  = magA % safeB;

  assign quot_o = (negA ^ negB) ? (32'd0 - magQ) : magQ;
  assign rem_o  = negA ? (32'd0 - magR) : magR;

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Define MDU_DIV_EN to include the divider and DIV_RUN; otherwise DIV/DIVU act as reserved ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(maxCycles(MULT_CYCLES, DIV_CYCLES)) + 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pendHi_q, pendHi_d;
  logic [31:0]      pendLo_q, pendLo_d;
  logic             commit_q, commit_d;

  logic [63:0]      prodS;
  logic [63:0]      prodU;

  // Sign-extending both operands to 64 bits makes the truncated product the signed result.
  assign prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prodU = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
  logic [31:0] divQuot;
  logic [31:0] divRem;
  logic        divZero;
  logic        divSigned;

  assign divSigned = (op == OP_DIV);

  mdu_div uDiv (
    .dividend_i (a),
    .divisor_i  (b),
    .signed_i   (divSigned),
    .quot_o     (divQuot),
    .rem_o      (divRem),
    .divZero_o  (divZero)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    commit_d = commit_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {pendHi_d, pendLo_d} = prodS;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES - 1);
              state_d  = MUL_RUN;
            end
            OP_MULTU: begin
              {pendHi_d, pendLo_d} = prodU;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES - 1);
              state_d  = MUL_RUN;
            end
`ifdef MDU_DIV_EN
            // A zero divisor still occupies the full latency but never commits.
            OP_DIV, OP_DIVU: begin
              pendHi_d = divRem;
              pendLo_d = divQuot;
              commit_d = ~divZero;
              cnt_d    = CNT_W'(DIV_CYCLES - 1);
              state_d  = DIV_RUN;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (cnt_q == '0) begin
          if (commit_q) begin
            hi_d = pendHi_q;
            lo_d = pendLo_q;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus random ops against a reference model.
// DIV checks follow whether MDU_DIV_EN is defined for the build.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int asserts  = 0;
  int failures = 0;

  logic [31:0] mHi;
  logic [31:0] mLo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: updates mHi/mLo from the architectural rules and returns busy length.
  task automatic modelOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
    longint      ps;
    logic [63:0] pu;
    longint      qs;
    longint      rs;
    n = 0;
    case (o)
      3'd0: begin
        ps  = longint'(int'(x)) * longint'(int'(y));
        mHi = ps[63:32];
        mLo = ps[31:0];
        n   = MC;
      end
      3'd1: begin
        pu  = 64'(x) * 64'(y);
        mHi = pu[63:32];
        mLo = pu[31:0];
        n   = MC;
      end
`ifdef MDU_DIV_EN
      3'd2: begin
        n = DC;
        if (y != 0) begin
          qs  = longint'(int'(x)) / longint'(int'(y));
          rs  = longint'(int'(x)) % longint'(int'(y));
          mLo = qs[31:0];
          mHi = rs[31:0];
        end
      end
      3'd3: begin
        n = DC;
        if (y != 0) begin
          mLo = x / y;
          mHi = x % y;
        end
      end
`endif
      3'd4: mHi = x;
      3'd5: mLo = x;
      default: ;
    endcase
  endtask

  // Issues one op and counts busy cycles (bounded); afterwards hi/lo should hold the result.
  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int n);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    reset = 1'b1;
    mHi = 32'd0; mLo = 32'd0;
  endtask

  task automatic test_mult();
    int n, e;
    modelOp(3'd0, 32'hFFFFFFFF, 32'd2, e);
    runOp(3'd0, 32'hFFFFFFFF, 32'd2, n);
    asserts++;
    if (n !== MC || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      failures++;
      $display("[TB] FAIL mult: busy=%0d hi=%h lo=%h expected %0d/ffffffff/fffffffe", n, hi, lo, MC);
    end
    modelOp(3'd1, 32'hFFFFFFFF, 32'd2, e);
    runOp(3'd1, 32'hFFFFFFFF, 32'd2, n);
    asserts++;
    if (n !== MC || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      failures++;
      $display("[TB] FAIL multu: busy=%0d hi=%h lo=%h expected %0d/00000001/fffffffe", n, hi, lo, MC);
    end
  endtask

  task automatic test_div();
    int n, e;
`ifdef MDU_DIV_EN
    modelOp(3'd2, 32'hFFFFFFF9, 32'd2, e);
    runOp(3'd2, 32'hFFFFFFF9, 32'd2, n);
    asserts++;
    if (n !== DC || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      failures++;
      $display("[TB] FAIL div_neg: busy=%0d hi=%h lo=%h expected %0d/ffffffff/fffffffd", n, hi, lo, DC);
    end
    modelOp(3'd3, 32'd7, 32'd0, e);
    runOp(3'd3, 32'd7, 32'd0, n);
    asserts++;
    if (n !== DC || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failures++;
      $display("[TB] FAIL divu_zero: busy=%0d hi=%h lo=%h expected %0d/ffffffff/fffffffd", n, hi, lo, DC);
    end
    modelOp(3'd2, 32'h80000000, 32'hFFFFFFFF, e);
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    asserts++;
    if (n !== DC || lo !== 32'h80000000 || hi !== 32'd0) begin
      failures++;
      $display("[TB] FAIL div_ovf: busy=%0d hi=%h lo=%h expected %0d/00000000/80000000", n, hi, lo, DC);
    end
`else
    logic [31:0] h0, l0;
    h0 = mHi; l0 = mLo;
    modelOp(3'd2, 32'd8, 32'd2, e);
    runOp(3'd2, 32'd8, 32'd2, n);
    asserts++;
    if (n !== 0 || hi !== h0 || lo !== l0) begin
      failures++;
      $display("[TB] FAIL div_disabled: busy=%0d hi=%h lo=%h expected 0/%h/%h", n, hi, lo, h0, l0);
    end
    runOp(3'd3, 32'd9, 32'd4, n);
    asserts++;
    if (n !== 0 || hi !== h0 || lo !== l0) begin
      failures++;
      $display("[TB] FAIL divu_disabled: busy=%0d hi=%h lo=%h expected 0/%h/%h", n, hi, lo, h0, l0);
    end
`endif
  endtask

  task automatic test_move();
    int e;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h12345678; b = 32'd0;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || hi !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL mthi: busy=%b hi=%h expected 0/12345678", busy, hi);
    end
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    asserts++;
    if (busy !== 1'b0 || lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL mtlo: busy=%b hi=%h lo=%h expected 0/12345678/9abcdef0", busy, hi, lo);
    end
    modelOp(3'd4, 32'h12345678, 32'd0, e);
    modelOp(3'd5, 32'h9ABCDEF0, 32'd0, e);
  endtask

  task automatic test_reserved();
    int n;
    for (int r = 6; r <= 7; r++) begin
      runOp(3'(r), $urandom, $urandom, n);
      asserts++;
      if (n !== 0 || hi !== mHi || lo !== mLo) begin
        failures++;
        $display("[TB] FAIL reserved_op%0d: busy=%0d hi=%h lo=%h expected 0/%h/%h",
                 r, n, hi, lo, mHi, mLo);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n, e;
    modelOp(3'd0, 32'h00001234, 32'hFFFF0003, e);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00001234; b = 32'hFFFF0003;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = 3'd1; a = 32'hDEADBEEF; b = 32'h00000777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    asserts++;
    if (n !== MC || hi !== mHi || lo !== mLo) begin
      failures++;
      $display("[TB] FAIL start_while_busy: busy=%0d hi=%h lo=%h expected %0d/%h/%h",
               n, hi, lo, MC, mHi, mLo);
    end
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_after_ignored: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    int n, late;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFF; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3) begin
      n++;
      if (n == 3) reset = 1'b0;
      @(negedge clk);
    end
    asserts++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_midop: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    reset = 1'b1;
    mHi = 32'd0; mLo = 32'd0;
    late = 0;
    repeat (MC + 5) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
    end
    asserts++;
    if (late !== 0) begin
      failures++;
      $display("[TB] FAIL no_late_commit: %0d bad cycles hi=%h lo=%h expected 0 bad cycles", late, hi, lo);
    end
  endtask

  task automatic test_reset_start();
    int n, bad;
    runOp(3'd4, 32'hCAFEF00D, 32'd0, n);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    bad = 0;
    repeat (MC + 3) begin
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
      @(negedge clk);
    end
    asserts++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL reset_edge_start: %0d bad cycles hi=%h lo=%h expected 0 bad cycles", bad, hi, lo);
    end
    mHi = 32'd0; mLo = 32'd0;
  endtask

  task automatic test_random();
    int n, e;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      modelOp(o, x, y, e);
      runOp(o, x, y, n);
      asserts++;
      if (n !== e || hi !== mHi || lo !== mLo) begin
        failures++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h expected %0d/%h/%h",
                 i, o, x, y, n, hi, lo, e, mHi, mLo);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    mHi = 32'd0; mLo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_reserved();
    test_start_while_busy();
    test_reset_midop();
    test_reset_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
